// File: rtl/sram_ctrl_if.sv
// CPU-side bus of the SRAM timing stage: one request/ack cycle per transfer.
// The master drives the request, the slave (sram_ctrl) returns data and ack.
interface sram_ctrl_if;
  logic [15:0] i_addr;
  logic [7:0]  i_dat;
  logic [7:0]  o_dat;
  logic        i_we;
  logic        i_cs;
  logic        o_ack;
  logic [1:0]  i_bank;

  modport master (output i_addr, i_dat, i_we, i_cs, i_bank, input o_dat, o_ack);
  modport slave  (input i_addr, i_dat, i_we, i_cs, i_bank, output o_dat, o_ack);
endinterface

// File: rtl/sram_ctrl.sv
// Sequences one CPU bus cycle into an asynchronous SRAM access:
// address setup, a wait-stretched strobe, data hold, then a registered ack.
module sram_ctrl #(
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  sram_ctrl_if.slave  bus,
  output logic [17:0] o_sram_addr,
  output logic [7:0]  o_sram_dout,
  output logic        o_sram_doe,
  input  logic [7:0]  i_sram_din,
  output logic        o_sram_cs_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, HOLD} state_t;

  state_t      state, state_nxt;
  logic        we_l, we_l_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [17:0] addr_nxt;
  logic [7:0]  dout_nxt, dat_nxt;
  logic        ack_nxt, cs_n_nxt, oe_n_nxt, we_n_nxt, doe_nxt;

  // Every output is a register; the *_nxt values describe the state being entered.
  always_comb begin
    state_nxt = state;
    we_l_nxt  = we_l;
    cnt_nxt   = cnt;
    addr_nxt  = o_sram_addr;
    dout_nxt  = o_sram_dout;
    dat_nxt   = bus.o_dat;
    ack_nxt   = 1'b0;
    cs_n_nxt  = 1'b1;
    oe_n_nxt  = 1'b1;
    we_n_nxt  = 1'b1;
    doe_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_cs) begin
          addr_nxt  = {bus.i_bank, bus.i_addr};
          dout_nxt  = bus.i_dat;
          we_l_nxt  = bus.i_we;
          state_nxt = SETUP;
          cs_n_nxt  = 1'b0;
          doe_nxt   = bus.i_we;
        end
      end
      SETUP: begin
        cnt_nxt   = we_l ? 4'(WR_WAIT) : 4'(RD_WAIT);
        state_nxt = ACCESS;
        cs_n_nxt  = 1'b0;
        oe_n_nxt  = we_l;
        we_n_nxt  = ~we_l;
        doe_nxt   = we_l;
      end
      ACCESS: begin
        cs_n_nxt = 1'b0;
        doe_nxt  = we_l;
        if (cnt == 4'd0) begin
          state_nxt = DONE;
          if (!we_l) dat_nxt = i_sram_din;
        end else begin
          cnt_nxt  = cnt - 4'd1;
          oe_n_nxt = we_l;
          we_n_nxt = ~we_l;
        end
      end
      DONE: begin
        state_nxt = HOLD;
        ack_nxt   = 1'b1;
      end
      HOLD: begin
        if (bus.i_cs) ack_nxt = 1'b1;
        else          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      we_l        <= 1'b0;
      cnt         <= '0;
      o_sram_addr <= '0;
      o_sram_dout <= '0;
      bus.o_dat   <= '0;
      bus.o_ack   <= 1'b0;
      o_sram_cs_n <= 1'b1;
      o_sram_oe_n <= 1'b1;
      o_sram_we_n <= 1'b1;
      o_sram_doe  <= 1'b0;
    end else begin
      state       <= state_nxt;
      we_l        <= we_l_nxt;
      cnt         <= cnt_nxt;
      o_sram_addr <= addr_nxt;
      o_sram_dout <= dout_nxt;
      bus.o_dat   <= dat_nxt;
      bus.o_ack   <= ack_nxt;
      o_sram_cs_n <= cs_n_nxt;
      o_sram_oe_n <= oe_n_nxt;
      o_sram_we_n <= we_n_nxt;
      o_sram_doe  <= doe_nxt;
    end
  end

  // The wait counter is only 4 bits wide.
  assert property (@(posedge i_clk) (RD_WAIT <= 15) && (WR_WAIT <= 15))
    else $error("sram_ctrl: RD_WAIT/WR_WAIT must be in 0..15");

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with an SRAM behavioural model and a queue of
// expected transfer results checked when o_ack rises.
module tb_sram_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] sram_addr;
  logic [7:0]  sram_dout, sram_din;
  logic        sram_doe, cs_n, oe_n, we_n;

  sram_ctrl_if bus ();

  sram_ctrl #(.RD_WAIT(2), .WR_WAIT(0)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .bus         (bus),
    .o_sram_addr (sram_addr),
    .o_sram_dout (sram_dout),
    .o_sram_doe  (sram_doe),
    .i_sram_din  (sram_din),
    .o_sram_cs_n (cs_n),
    .o_sram_oe_n (oe_n),
    .o_sram_we_n (we_n)
  );

  always #20 clk = ~clk;

  // SRAM model: reads are combinational while selected and enabled,
  // writes land mid-cycle while we_n is low and the bus is driven.
  logic [7:0] mem [0:262143];
  assign sram_din = (!cs_n && !oe_n) ? mem[sram_addr] : 8'hEE;

  initial begin
    mem[18'h21234] = 8'hA5;
    mem[18'h10055] = 8'h5A;
    mem[18'h00010] = 8'h11;
    mem[18'h00020] = 8'h22;
    forever begin
      @(negedge clk);
      if (!we_n && !cs_n && sram_doe) mem[sram_addr] = sram_dout;
    end
  end

  // Cumulative strobe/ack activity and contention monitor.
  int          n_oe = 0, n_we = 0, n_doe = 0, n_ack = 0, n_clash = 0;
  logic [17:0] strobe_addr = '0;
  always @(negedge clk) begin
    if (!oe_n)     n_oe++;
    if (!we_n)     n_we++;
    if (sram_doe)  n_doe++;
    if (bus.o_ack) n_ack++;
    if (!oe_n || !we_n) strobe_addr = sram_addr;
    assert (!(sram_doe && !oe_n) && !(!we_n && !oe_n)) else begin
      n_clash++;
      $error("FAIL bus_clash doe=%b oe_n=%b we_n=%b", sram_doe, oe_n, we_n);
    end
  end

  typedef struct {
    logic        rd;
    logic [17:0] addr;
    logic [7:0]  dat;
  } exp_t;
  exp_t sb[$];

  int         total = 0, bad = 0;
  logic [7:0] exp_odat = 8'h00;
  int         b_oe, b_we, b_doe, b_ack;
  int         lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the request is sampled on the following posedge.
  task automatic start(input logic we, input logic [1:0] bank, input logic [15:0] addr,
                       input logic [7:0] dat);
    exp_t e;
    bus.i_we   = we;
    bus.i_bank = bank;
    bus.i_addr = addr;
    bus.i_dat  = we ? dat : 8'h00;
    bus.i_cs   = 1'b1;
    e.rd = ~we; e.addr = {bank, addr}; e.dat = dat;
    sb.push_back(e);
    b_oe = n_oe; b_we = n_we; b_doe = n_doe; b_ack = n_ack;
  endtask

  // lat = number of posedges after the request edge until ack is seen.
  task automatic wait_ack(input int drop_at, input int chg_at, output int l);
    exp_t e;
    l = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == drop_at) bus.i_cs = 1'b0;
      if (i == chg_at) begin
        bus.i_addr = 16'h0020;
        bus.i_we   = 1'b1;
      end
      if (bus.o_ack) begin
        l = i;
        break;
      end
    end
    if (l < 0) chk("ack_timeout", 32'd0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sram_addr", 32'(sram_addr), 32'(e.addr));
      if (e.rd) exp_odat = e.dat;
      else      chk("mem_write", 32'(mem[e.addr]), 32'(e.dat));
      chk("o_dat", 32'(bus.o_dat), 32'(exp_odat));
    end else begin
      chk("sb_empty", 32'd1, 32'(sb.size()));
    end
  endtask

  task automatic finish_txn();
    bus.i_cs = 1'b0;
    @(negedge clk);
    chk("ack_drop", 32'(bus.o_ack), 32'd0);
  endtask

  initial begin
    bus.i_cs = 1'b0; bus.i_we = 1'b0; bus.i_addr = '0; bus.i_dat = '0; bus.i_bank = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack",  32'(bus.o_ack), 32'd0);
    chk("rst_odat", 32'(bus.o_dat), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dout", 32'(sram_dout), 32'd0);
    chk("rst_strb", 32'({sram_doe, cs_n, oe_n, we_n}), 32'b0111);
    rst = 1'b0;
    @(negedge clk);

    // Read with default wait: bank 2, addr 0x1234.
    start(1'b0, 2'd2, 16'h1234, 8'hA5);
    wait_ack(-1, -1, lat);
    chk("rd_latency", 32'(lat), 32'd5);
    chk("rd_oe_cycles", 32'(n_oe - b_oe), 32'd3);
    chk("rd_we_cycles", 32'(n_we - b_we), 32'd0);
    chk("rd_doe_cycles", 32'(n_doe - b_doe), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rd_ack_held", 32'(bus.o_ack), 32'd1);
    end
    finish_txn();
    @(negedge clk);

    // Write with zero wait.
    start(1'b1, 2'd0, 16'h00FF, 8'h3C);
    wait_ack(-1, -1, lat);
    chk("wr_latency", 32'(lat), 32'd3);
    chk("wr_we_cycles", 32'(n_we - b_we), 32'd1);
    chk("wr_doe_cycles", 32'(n_doe - b_doe), 32'd3);
    chk("wr_oe_cycles", 32'(n_oe - b_oe), 32'd0);
    finish_txn();
    @(negedge clk);

    // i_cs dropped during SETUP of a read.
    start(1'b0, 2'd1, 16'h0055, 8'h5A);
    wait_ack(0, -1, lat);
    chk("drop_latency", 32'(lat), 32'd5);
    @(negedge clk);
    chk("drop_ack_low", 32'(bus.o_ack), 32'd0);
    repeat (4) @(negedge clk);
    chk("drop_ack_cycles", 32'(n_ack - b_ack), 32'd1);
    chk("drop_oe_cycles", 32'(n_oe - b_oe), 32'd3);
    chk("drop_idle_cs_n", 32'(cs_n), 32'd1);

    // Address and direction change mid-ACCESS are ignored.
    start(1'b0, 2'd0, 16'h0010, 8'h11);
    wait_ack(-1, 2, lat);
    chk("chg_latency", 32'(lat), 32'd5);
    chk("chg_strobe_addr", 32'(strobe_addr), 32'h00010);
    chk("chg_we_cycles", 32'(n_we - b_we), 32'd0);
    chk("chg_oe_cycles", 32'(n_oe - b_oe), 32'd3);
    finish_txn();
    @(negedge clk);

    // Back-to-back write then read of the same location.
    start(1'b1, 2'd2, 16'h4444, 8'h77);
    wait_ack(-1, -1, lat);
    chk("b2b_wr_latency", 32'(lat), 32'd3);
    finish_txn();
    start(1'b0, 2'd2, 16'h4444, 8'h77);
    wait_ack(-1, -1, lat);
    chk("b2b_rd_latency", 32'(lat), 32'd5);
    finish_txn();
    @(negedge clk);

    // Reset while we_n is low during a write.
    start(1'b1, 2'd3, 16'hABCD, 8'h99);
    repeat (2) @(negedge clk);
    chk("mid_we_low", 32'(we_n), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_strb", 32'({sram_doe, cs_n, oe_n, we_n}), 32'b0111);
    chk("mid_rst_ack", 32'(bus.o_ack), 32'd0);
    chk("mid_rst_odat", 32'(bus.o_dat), 32'd0);
    exp_odat = 8'h00;
    sb.delete();
    bus.i_cs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start(1'b0, 2'd2, 16'h1234, 8'hA5);
    wait_ack(-1, -1, lat);
    chk("post_rst_latency", 32'(lat), 32'd5);
    finish_txn();
    repeat (2) @(negedge clk);

    chk("bus_clash_count", 32'(n_clash), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Bus-to-SRAM timing stage that sits directly downstream of the z80computer external bus (o_addr/o_dat/i_dat/o_we/o_cs/i_ack), replacing the fixed ack=1 glue in the FPGA top.
- Converts a single CPU bus cycle into a correctly sequenced asynchronous SRAM access: address setup, a strobe pulse stretched by a programmable number of wait cycles, and data hold.
- Registers read data and returns i_ack to the CPU.
- Board-level tristate remains in the top; this block only drives data-out and output-enable signals.

Parameters:
- RD_WAIT, 2, extra cycles beyond one during which sram_oe_n is held low on a read (range 0..15).
- WR_WAIT, 2, extra cycles beyond one during which sram_we_n is held low on a write (range 0..15).

Ports:
- i_clk  in  1  system clock (25 MHz).
- i_reset  in  1  asynchronous, active-high reset.
- i_addr  in  16  CPU address.
- i_dat  in  8  CPU write data.
- o_dat  out  8  registered read data to CPU.
- i_we  in  1  CPU write request (1 = write).
- i_cs  in  1  CPU bus cycle request.
- o_ack  out  1  transfer complete.
- i_bank  in  2  upper SRAM address bits.
- o_sram_addr  out  18  SRAM address, {bank, addr}.
- o_sram_dout  out  8  data to drive onto SRAM bus.
- o_sram_doe  out  1  top drives o_sram_dout onto the pins when 1.
- i_sram_din  in  8  SRAM pin data.
- o_sram_cs_n  out  1  SRAM chip select, active low.
- o_sram_oe_n  out  1  SRAM output enable, active low.
- o_sram_we_n  out  1  SRAM write enable, active low.

Behaviour:
- Reset values (asynchronous assert, released on clock edge):
  - state = IDLE.
  - o_ack = 0, o_dat = 0, o_sram_addr = 0, o_sram_dout = 0, o_sram_doe = 0.
  - o_sram_cs_n = 1, o_sram_oe_n = 1, o_sram_we_n = 1.
  - Wait counter = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States:
  - IDLE: when i_cs = 1, latch {i_bank, i_addr} into o_sram_addr, i_dat into o_sram_dout, and i_we into an internal we_l flag; go to SETUP.
  - SETUP (1 cycle): o_sram_cs_n = 0; both strobes high; o_sram_doe = we_l. Load counter = (we_l ? WR_WAIT : RD_WAIT); go to ACCESS.
  - ACCESS:
    - Read: o_sram_oe_n = 0. Write: o_sram_we_n = 0 and o_sram_doe = 1.
    - Counter decrements each cycle. On the edge where counter = 0, go to DONE.
    - For a read, capture i_sram_din into o_dat on that same edge.
    - ACCESS therefore lasts WAIT+1 cycles.
  - DONE: strobes high; o_sram_cs_n = 0 for this one cycle; o_sram_doe stays = we_l (data hold); o_ack = 1. Go to HOLD.
  - HOLD: o_sram_cs_n = 1, o_sram_doe = 0, o_ack = 1 while i_cs = 1. When i_cs = 0: o_ack = 0 on the next edge, go to IDLE.
- Latency: with i_cs first sampled high on edge 0, o_ack rises after edge 3+WAIT. Defaults: edge 5 (5 cycles).
- Address, write data and we_l are frozen from the IDLE→SETUP edge to the end of the transaction. Changes on i_addr, i_dat or i_we mid-transaction are ignored.
- i_cs deasserted during SETUP/ACCESS: the transaction still completes; no SRAM strobe is ever truncated. In DONE, o_ack pulses for exactly 1 cycle, then HOLD sees i_cs = 0 and the block returns to IDLE.
- Back-to-back requests: a new transaction starts only from IDLE. i_cs must be low for at least 1 sampled cycle between transactions.
- Bus contention guard: o_sram_doe and a low o_sram_oe_n are never asserted in the same cycle. o_sram_we_n and o_sram_oe_n are never low together.
- Reset mid-transaction: strobes deassert immediately (asynchronous), o_sram_doe = 0, o_ack = 0, state = IDLE. The read data register is cleared.
- Wait counter is 4 bits; parameters above 15 are illegal. A simulation-only check is required to flag them.
- o_dat holds the last read value until the next read capture or reset; it is unchanged by writes.

Test Plan:
- Reset mid-ACCESS of a write (we_n low) → o_sram_we_n = 1, o_sram_doe = 0, o_ack = 0 asynchronously; state IDLE. After release, an i_cs = 1 read starts a normal SETUP.
- Read with defaults: i_addr = 0x1234, i_bank = 2, SRAM model returns 0xA5 → o_sram_addr = 0x21234, oe_n low exactly 3 cycles, o_dat = 0xA5, o_ack rises after edge 5 and stays high until i_cs drops.
- Write with WR_WAIT = 0: i_addr = 0x00FF, i_dat = 0x3C → we_n low 1 cycle, o_sram_doe high for SETUP+ACCESS+DONE (3 cycles), SRAM model holds 0x3C at 0x000FF, o_dat unchanged.
- i_cs dropped during SETUP of a read → oe_n pulse still full length, o_ack high for exactly 1 cycle, return to IDLE, no second access.
- Mid-transaction input change: i_addr 0x0010→0x0020 and i_we 0→1 during ACCESS → SRAM address stays 0x00010, access stays a read, we_n never low.
- Back-to-back write then read of the same address, i_cs low 1 cycle between → read returns the written value. Across the run, never doe=1 with oe_n=0, and never we_n=0 with oe_n=0 (assertion checked every cycle).
